ahb_regfile_ctrl: RTL and testbench
===================================

// Module: ahb_regfile_ctrl
// PURPOSE
//  AHB-Lite slave front end that sequences the register file inside the AHB slave.
//  Decodes address-phase signals and drives single-cycle RF write/read strobes.
//  Inserts wait states for the registered RF read and raises two-cycle ERROR
//  responses for illegal transfers or read timeout. Sole master of the RF port.
// PARAMETERS
//  DATA_W   8   data width of bus and RF; legal values 8/16/32
//  DEPTH    4   RF address bits; 2**DEPTH entries
//  ADDR_W   32  HADDR width
//  TIMEOUT  4   max cycles to wait for RF_RdData_Valid after RF_Rden; legal 1..15
//  ALIGN    derived = log2(DATA_W/8); it is not user-set
// PORTS
//  CLK              in   1       clock, rising edge
//  RST              in   1       asynchronous reset, active-low
//  HSEL             in   1       slave select
//  HADDR            in   ADDR_W  byte address
//  HTRANS           in   2       00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  HWRITE           in   1       1 = write
//  HSIZE            in   3       transfer size
//  HWDATA           in   DATA_W  write data; valid in data phase
//  HREADY           in   1       bus ready, which is the previous data phase complete
//  HREADYOUT        out  1       slave ready
//  HRESP            out  1       0 OKAY, 1 ERROR
//  HRDATA           out  DATA_W  read data, registered
//  RF_Wren          out  1       RF write strobe, one cycle
//  RF_Rden          out  1       RF read strobe, one cycle
//  RF_WrData        out  DATA_W  RF write data
//  RF_Adresse       out  DEPTH   RF word address
//  RF_RdData        in   DATA_W  RF read data
//  RF_RdData_Valid  in   1       RF read data valid
//  ERR_CNT          out  8       saturating count of ERROR responses
// BEHAVIOUR
//  Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, RF_Wren=0, RF_Rden=0,
//   RF_WrData=0, RF_Adresse=0, ERR_CNT=0, FSM=IDLE, timeout count=0.
//  Accept: the address phase is accepted when HSEL & HREADY & HTRANS[1] in any state with
//   HREADYOUT=1 (IDLE, WR, RD_DONE, ERR2). Latch HWRITE, word index
//   HADDR[DEPTH+ALIGN-1:ALIGN]. IDLE/BUSY/unselected transfers: OKAY, zero wait, no RF access.
//  Check at accept: error if HSIZE!=ALIGN, HADDR[ALIGN-1:0]!=0, or HADDR[ADDR_W-1:DEPTH+ALIGN]!=0.
//   When a check fails, go to ERR1 and issue no RF access.
//  FSM (next state chosen from the new address phase in accepting states):
//   IDLE    HREADYOUT=1; a legal write goes to WR, a legal read goes to RD_REQ, a failed check goes to ERR1.
//   WR      zero-wait data phase: RF_Wren=1, RF_WrData=HWDATA, RF_Adresse=latched
//           index (RF_Wren/RF_WrData combinational); HREADYOUT=1; pipelined accept.
//   RD_REQ  RF_Rden=1 exactly one cycle, HREADYOUT=0; then RD_WAIT with count=0.
//   RD_WAIT HREADYOUT=0. If RF_RdData_Valid, then HRDATA<=RF_RdData and go to RD_DONE;
//           otherwise count++. When count reaches TIMEOUT, go to ERR1 and leave HRDATA unchanged.
//   RD_DONE HREADYOUT=1, HRESP=0, HRDATA stable; pipelined accept.
//   ERR1    HREADYOUT=0, HRESP=1.  ERR2  HREADYOUT=1, HRESP=1; pipelined accept.
//  Read latency is two wait states minimum; the RD_REQ address phase is 4 cycles to completion.
//  RF_Wren & RF_Rden are never both 1. RF_Adresse holds the last index when idle.
//  ERR_CNT increments on entry to ERR1 and saturates at 255.
//  Inputs are ignored while HREADYOUT=0; the master holds them, per the AHB rules.
//  Reset mid-transfer aborts immediately to reset values, and no RF strobe is left pending.
// TESTING
//  Write 0x5A to HADDR 0x3, then read 0x3 -> 1 RF_Wren cycle, RF_Adresse=3;
//   read HREADYOUT low 2 cycles, HRDATA=0x5A, HRESP=0.
//  Back-to-back NONSEQ writes to 0x1,0x2 -> 2 consecutive RF_Wren cycles, no wait states.
//  HSIZE=001 with DATA_W=8 -> ERROR: HRESP=1 for 2 cycles, HREADYOUT 0 then 1,
//   no RF strobe, ERR_CNT=1.
//  HADDR=0x20 (beyond 16 entries) -> two-cycle ERROR, no RF access.
//  Read with RF_RdData_Valid held 0 -> 4 RD_WAIT cycles then ERROR; HRDATA unchanged.
//  RST low during RD_WAIT -> all outputs at reset values in the same cycle;
//   the next read completes normally.

Source files
------------

// File: rtl/ahb_regfile_ctrl_if.sv
// rtl/ahb_regfile_ctrl_if.sv - AHB-Lite slave-side bus bundle for the register file controller
interface ahb_regfile_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8
);
  logic              HSEL;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [DATA_W-1:0] HWDATA;
  logic              HREADY;
  logic              HREADYOUT;
  logic              HRESP;
  logic [DATA_W-1:0] HRDATA;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_regfile_ctrl.sv
// rtl/ahb_regfile_ctrl.sv - AHB-Lite slave front end sequencing a registered-read register file
// Zero-wait writes, two-wait-state reads, two-cycle ERROR for illegal transfers or read timeout.
module ahb_regfile_ctrl #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 4
) (
  input  logic                CLK,
  input  logic                RST,
  ahb_regfile_ctrl_if.slave   bus,
  output logic                RF_Wren,
  output logic                RF_Rden,
  output logic [DATA_W-1:0]   RF_WrData,
  output logic [DEPTH-1:0]    RF_Adresse,
  input  logic [DATA_W-1:0]   RF_RdData,
  input  logic                RF_RdData_Valid,
  output logic [7:0]          ERR_CNT
);

  localparam int ALIGN = $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << ALIGN) - 64'd1);
  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, WR, RD_REQ, RD_WAIT, RD_DONE, ERR1, ERR2
  } state_t;

  state_t            state, state_n;
  logic [3:0]        cnt;
  logic [DEPTH-1:0]  idx_q;
  logic [DATA_W-1:0] hrdata_q;
  logic [7:0]        err_q;

  logic              ready;
  logic              active;
  logic              legal;
  logic [DEPTH-1:0]  index;

  // Slave is ready only in states whose data phase completes this cycle.
  assign ready  = (state == IDLE) || (state == WR) || (state == RD_DONE) || (state == ERR2);
  assign active = bus.HSEL && bus.HREADY && ((bus.HTRANS == 2'b10) || (bus.HTRANS == 2'b11));
  assign legal  = (bus.HSIZE == 3'(ALIGN)) &&
                  ((bus.HADDR & ALIGN_MASK) == '0) &&
                  ((bus.HADDR >> (DEPTH + ALIGN)) == '0);
  assign index  = bus.HADDR[DEPTH+ALIGN-1:ALIGN];

  always_comb begin
    state_n = state;
    case (state)
      RD_REQ:  state_n = RD_WAIT;
      RD_WAIT: begin
        if (RF_RdData_Valid)
          state_n = RD_DONE;
        else if (cnt == CNT_LAST)
          state_n = ERR1;
      end
      ERR1:    state_n = ERR2;
      default: begin
        state_n = IDLE;
        if (active) begin
          if (!legal)
            state_n = ERR1;
          else if (bus.HWRITE)
            state_n = WR;
          else
            state_n = RD_REQ;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      cnt      <= '0;
      idx_q    <= '0;
      hrdata_q <= '0;
      err_q    <= '0;
    end else begin
      state <= state_n;
      if (ready && active && legal)
        idx_q <= index;
      if (state == RD_REQ)
        cnt <= '0;
      else if (state == RD_WAIT && !RF_RdData_Valid)
        cnt <= cnt + 4'd1;
      if (state == RD_WAIT && RF_RdData_Valid)
        hrdata_q <= RF_RdData;
      // ERR1 is always entered from a different state, so this counts each response once.
      if (state_n == ERR1 && state != ERR1 && err_q != 8'hFF)
        err_q <= err_q + 8'd1;
    end
  end

  assign bus.HREADYOUT = ready;
  assign bus.HRESP     = (state == ERR1) || (state == ERR2);
  assign bus.HRDATA    = hrdata_q;
  assign RF_Wren       = (state == WR);
  assign RF_Rden       = (state == RD_REQ);
  assign RF_WrData     = (state == WR) ? bus.HWDATA : '0;
  assign RF_Adresse    = idx_q;
  assign ERR_CNT       = err_q;

endmodule

// File: tb/tb_ahb_regfile_ctrl.sv
// tb/tb_ahb_regfile_ctrl.sv - directed self-checking bench for ahb_regfile_ctrl
module tb_ahb_regfile_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RF_Wren, RF_Rden;
  logic [7:0] RF_WrData;
  logic [3:0] RF_Adresse;
  logic [7:0] RF_RdData = 8'h00;
  logic       RF_RdData_Valid = 1'b0;
  logic [7:0] ERR_CNT;
  logic       rf_stall = 1'b0;
  logic [7:0] rf_mem [16];

  int checks = 0;
  int errors = 0;

  ahb_regfile_ctrl_if #(.ADDR_W(32), .DATA_W(8)) bus ();

  assign bus.HREADY = bus.HREADYOUT;

  ahb_regfile_ctrl #(.DATA_W(8), .DEPTH(4), .ADDR_W(32), .TIMEOUT(4)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .bus             (bus),
    .RF_Wren         (RF_Wren),
    .RF_Rden         (RF_Rden),
    .RF_WrData       (RF_WrData),
    .RF_Adresse      (RF_Adresse),
    .RF_RdData       (RF_RdData),
    .RF_RdData_Valid (RF_RdData_Valid),
    .ERR_CNT         (ERR_CNT)
  );

  always #5 CLK = ~CLK;

  // Registered-read register file model.
  always @(posedge CLK) begin
    if (RF_Wren) rf_mem[RF_Adresse] <= RF_WrData;
    RF_RdData       <= rf_mem[RF_Adresse];
    RF_RdData_Valid <= RF_Rden && !rf_stall;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic addr_phase(input logic wr, input logic [31:0] addr, input logic [2:0] size);
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HWRITE = wr;
    bus.HADDR  = addr;
    bus.HSIZE  = size;
  endtask

  task automatic bus_idle();
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf_mem[i] = 8'h00;
    bus.HADDR  = '0;
    bus.HSIZE  = 3'b000;
    bus.HWDATA = '0;
    bus_idle();
    #12;
    check("rst_hreadyout", {31'd0, bus.HREADYOUT}, 32'd1);
    check("rst_hresp",     {31'd0, bus.HRESP},     32'd0);
    check("rst_hrdata",    {24'd0, bus.HRDATA},    32'd0);
    check("rst_strobes",   {30'd0, RF_Wren, RF_Rden}, 32'd0);
    check("rst_errcnt",    {24'd0, ERR_CNT},       32'd0);
    RST = 1'b1;
    tick();

    // Write 0x5A to 0x3.
    addr_phase(1'b1, 32'h3, 3'b000);
    tick();
    bus_idle();
    bus.HWDATA = 8'h5A;
    #1;
    check("wr_wren",  {31'd0, RF_Wren},    32'd1);
    check("wr_data",  {24'd0, RF_WrData},  32'h5A);
    check("wr_addr",  {28'd0, RF_Adresse}, 32'd3);
    check("wr_ready", {31'd0, bus.HREADYOUT}, 32'd1);
    tick();
    check("wr_done_wren", {31'd0, RF_Wren}, 32'd0);

    // Read 0x3: two wait states, then data.
    addr_phase(1'b0, 32'h3, 3'b000);
    tick();
    bus_idle();
    #1;
    check("rd_req_ready", {31'd0, bus.HREADYOUT}, 32'd0);
    check("rd_req_rden",  {31'd0, RF_Rden},       32'd1);
    check("rd_req_addr",  {28'd0, RF_Adresse},    32'd3);
    tick();
    check("rd_wait_ready", {31'd0, bus.HREADYOUT}, 32'd0);
    check("rd_wait_rden",  {31'd0, RF_Rden},       32'd0);
    tick();
    check("rd_done_ready", {31'd0, bus.HREADYOUT}, 32'd1);
    check("rd_done_data",  {24'd0, bus.HRDATA},    32'h5A);
    check("rd_done_resp",  {31'd0, bus.HRESP},     32'd0);
    tick();

    // Back-to-back writes to 0x1 and 0x2.
    addr_phase(1'b1, 32'h1, 3'b000);
    tick();
    addr_phase(1'b1, 32'h2, 3'b000);
    bus.HWDATA = 8'h11;
    #1;
    check("b2b_w1_wren",  {31'd0, RF_Wren},    32'd1);
    check("b2b_w1_addr",  {28'd0, RF_Adresse}, 32'd1);
    check("b2b_w1_ready", {31'd0, bus.HREADYOUT}, 32'd1);
    tick();
    bus_idle();
    bus.HWDATA = 8'h22;
    #1;
    check("b2b_w2_wren", {31'd0, RF_Wren},    32'd1);
    check("b2b_w2_addr", {28'd0, RF_Adresse}, 32'd2);
    check("b2b_w2_data", {24'd0, RF_WrData},  32'h22);
    tick();
    check("b2b_end_wren", {31'd0, RF_Wren}, 32'd0);

    // HSIZE=001 on an 8-bit bus.
    addr_phase(1'b1, 32'h0, 3'b001);
    tick();
    bus_idle();
    #1;
    check("size_err1_ready", {31'd0, bus.HREADYOUT}, 32'd0);
    check("size_err1_resp",  {31'd0, bus.HRESP},     32'd1);
    check("size_err1_strb",  {30'd0, RF_Wren, RF_Rden}, 32'd0);
    check("size_errcnt",     {24'd0, ERR_CNT},       32'd1);
    tick();
    check("size_err2_ready", {31'd0, bus.HREADYOUT}, 32'd1);
    check("size_err2_resp",  {31'd0, bus.HRESP},     32'd1);
    check("size_err2_strb",  {30'd0, RF_Wren, RF_Rden}, 32'd0);
    tick();
    check("size_after_resp", {31'd0, bus.HRESP}, 32'd0);

    // Address 0x20 is beyond the 16-entry file.
    addr_phase(1'b0, 32'h20, 3'b000);
    tick();
    bus_idle();
    #1;
    check("range_err1_resp", {31'd0, bus.HRESP}, 32'd1);
    check("range_err1_strb", {30'd0, RF_Wren, RF_Rden}, 32'd0);
    check("range_errcnt",    {24'd0, ERR_CNT}, 32'd2);
    tick();
    check("range_err2_ready", {31'd0, bus.HREADYOUT}, 32'd1);
    check("range_err2_strb",  {30'd0, RF_Wren, RF_Rden}, 32'd0);
    tick();

    // Read timeout: valid never arrives.
    rf_stall = 1'b1;
    addr_phase(1'b0, 32'h1, 3'b000);
    tick();
    bus_idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("to_wait_ready", {31'd0, bus.HREADYOUT}, 32'd0);
      check("to_wait_resp",  {31'd0, bus.HRESP},     32'd0);
    end
    tick();
    check("to_err1_ready", {31'd0, bus.HREADYOUT}, 32'd0);
    check("to_err1_resp",  {31'd0, bus.HRESP},     32'd1);
    check("to_hrdata",     {24'd0, bus.HRDATA},    32'h5A);
    check("to_errcnt",     {24'd0, ERR_CNT},       32'd3);
    tick();
    check("to_err2_ready", {31'd0, bus.HREADYOUT}, 32'd1);
    tick();
    rf_stall = 1'b0;

    // Error counter saturation.
    for (int i = 0; i < 253; i++) begin
      addr_phase(1'b1, 32'h1, 3'b010);
      tick();
      bus_idle();
      tick();
      tick();
    end
    check("errcnt_sat", {24'd0, ERR_CNT}, 32'd255);

    // Reset during RD_WAIT, then a clean read of 0x2.
    addr_phase(1'b0, 32'h3, 3'b000);
    tick();
    bus_idle();
    tick();
    check("pre_rst_state", {31'd0, bus.HREADYOUT}, 32'd0);
    RST = 1'b0;
    #1;
    check("midrst_ready",  {31'd0, bus.HREADYOUT}, 32'd1);
    check("midrst_strobe", {30'd0, RF_Wren, RF_Rden}, 32'd0);
    check("midrst_hrdata", {24'd0, bus.HRDATA},    32'd0);
    check("midrst_addr",   {28'd0, RF_Adresse},    32'd0);
    check("midrst_errcnt", {24'd0, ERR_CNT},       32'd0);
    tick();
    RST = 1'b1;
    tick();
    addr_phase(1'b0, 32'h2, 3'b000);
    tick();
    bus_idle();
    #1;
    check("post_rst_rden", {31'd0, RF_Rden}, 32'd1);
    tick();
    tick();
    check("post_rst_ready", {31'd0, bus.HREADYOUT}, 32'd1);
    check("post_rst_data",  {24'd0, bus.HRDATA},    32'h22);
    check("post_rst_resp",  {31'd0, bus.HRESP},     32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
